// File: rtl/prcoder_if.sv
// Request/encoded-result bundle for the priority encoder.
// The master drives the request vector; the slave returns the registered encoding.
interface prcoder_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CODE_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0]  in;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              multi;

  modport master (output in, input code, input valid, input multi);
  modport slave  (input in, output code, output valid, output multi);
endinterface

// File: rtl/prcoder.sv
// Registered WIDTH-to-log2(WIDTH) priority encoder: highest set request index wins,
// with valid (any request) and multi (two or more requests) flags, one clock of latency.
module prcoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CODE_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  prcoder_if.slave bus
);

  logic [CODE_W-1:0] code_d, code_q;
  logic              valid_d, valid_q;
  logic              multi_d, multi_q;

  // Ascending scan: a later (higher) set bit overwrites the code, and any set bit
  // seen after an earlier one marks a multiple request.
  always_comb begin
    code_d  = '0;
    valid_d = 1'b0;
    multi_d = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bus.in[i]) begin
        multi_d = multi_d | valid_d;
        valid_d = 1'b1;
        code_d  = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

endmodule

// File: tb/tb_prcoder.sv
// Self-checking bench for prcoder: vector table, exhaustive and random sweeps
// against a reference model, plus reset, latency and hold sequences.
module tb_prcoder;

  typedef struct {
    logic [7:0] in;
    logic [2:0] code;
    logic       valid;
    logic       multi;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  prcoder_if #(.WIDTH(8)) bus ();

  prcoder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan from the top bit down for the winner; counts by popcount.
  function automatic vec_t model(input logic [7:0] v);
    vec_t r;
    r.in    = v;
    r.code  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        r.code = 3'(k);
        break;
      end
    end
    r.valid = (v != 8'd0);
    r.multi = ($countones(v) >= 2);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] ec, input logic ev, input logic em);
    checks++;
    if (bus.code !== ec || bus.valid !== ev || bus.multi !== em) begin
      errors++;
      $display("FAIL %s: in=%02h got code=%0d valid=%b multi=%b, want code=%0d valid=%b multi=%b",
               name, bus.in, bus.code, bus.valid, bus.multi, ec, ev, em);
    end
  endtask

  task automatic apply_model(input string name, input logic [7:0] v);
    vec_t e;
    bus.in = v;
    tick();
    e = model(v);
    check(name, e.code, e.valid, e.multi);
  endtask

  vec_t tbl [10];

  initial begin
    errors = 0;
    checks = 0;
    tbl[0] = '{8'h01, 3'd0, 1'b1, 1'b0};
    tbl[1] = '{8'h02, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{8'h03, 3'd1, 1'b1, 1'b1};
    tbl[3] = '{8'h80, 3'd7, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 3'd7, 1'b1, 1'b1};
    tbl[5] = '{8'h56, 3'd6, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7] = '{8'h10, 3'd4, 1'b1, 1'b0};
    tbl[8] = '{8'h81, 3'd7, 1'b1, 1'b1};
    tbl[9] = '{8'h0C, 3'd3, 1'b1, 1'b1};

    // Reset held with all requests active.
    rst    = 1'b1;
    bus.in = 8'hFF;
    tick();
    check("reset_c1", 3'd0, 1'b0, 1'b0);
    tick();
    check("reset_c2", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check("reset_release", 3'd7, 1'b1, 1'b1);

    // Table-driven spot vectors.
    for (int i = 0; i < 10; i++) begin
      bus.in = tbl[i].in;
      tick();
      check($sformatf("table_%0d", i), tbl[i].code, tbl[i].valid, tbl[i].multi);
    end

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) apply_model($sformatf("sweep_%02h", v), 8'(v));

    // Zero versus bit-0 alone.
    bus.in = 8'h00;
    tick();
    check("zero", 3'd0, 1'b0, 1'b0);
    bus.in = 8'h01;
    tick();
    check("bit0", 3'd0, 1'b1, 1'b0);

    // Single-hot walk.
    for (int k = 0; k < 8; k++) begin
      bus.in = 8'(1 << k);
      tick();
      check($sformatf("walk_%0d", k), 3'(k), 1'b1, 1'b0);
    end

    // Reset in the middle of a stream.
    bus.in = 8'h40;
    tick();
    check("mid_pre", 3'd6, 1'b1, 1'b0);
    rst    = 1'b1;
    bus.in = 8'h20;
    tick();
    check("mid_rst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check("mid_post", 3'd5, 1'b1, 1'b0);

    // Hold for three cycles, then change between edges.
    bus.in = 8'h24;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("hold_%0d", c), 3'd5, 1'b1, 1'b1);
    end
    #2 bus.in = 8'h01;
    #1 check("between_edges", 3'd5, 1'b1, 1'b1);
    tick();
    check("after_edge", 3'd0, 1'b1, 1'b0);

    // Random back-to-back stimulus.
    for (int r = 0; r < 300; r++) apply_model($sformatf("rand_%0d", r), 8'($urandom_range(0, 255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prcoder.md
# prcoder

Registered 8-to-3 priority encoder. It reports the index of the highest-order asserted bit of an 8-bit request vector as a 3-bit code, together with a valid flag and a multiple-request flag. It sits between request/flag sources and downstream logic that needs a single encoded winner per cycle. All outputs are registered on the single system clock.

## Interface

- WIDTH, default 8: request vector width. Must be a power of two, ≥ 2.
- CODE_W, default $clog2(WIDTH) = 3: code width.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- in  input  WIDTH  request vector; bit i set means request i is active.
- code  output  CODE_W  index of the highest set bit of `in`, registered.
- valid  output  1  registered; 1 when at least one bit of `in` was set.
- multi  output  1  registered; 1 when two or more bits of `in` were set.

## Operation

- Priority: highest index wins. code = max{ i : in[i] = 1 }.
  - Examples: in=8'b1000_0000 → code=7. in=8'b0000_0001 → code=0. in=8'b0101_0110 → code=6. in=8'b1111_1111 → code=7.
- All-zero input: in=0 → code=0, valid=0, multi=0.
  - code=0 with valid=0 is the "no request" encoding.
  - code=0 with valid=1 means bit 0 alone won.
- valid = OR-reduction of `in`.
- multi = 1 when popcount(in) ≥ 2.
  - Examples: in=8'h03 → multi=1. in=8'h80 → multi=0.
- Encoding is purely a function of the `in` sampled at the clock edge. No history, no state beyond the output registers.
- Unknown or X input bits are not resolved. Behaviour under X input is undefined; the bench drives only 0/1.
- Implementation: generic over WIDTH, for example as a loop or tree. Not a hard-coded 8-entry case.

## Timing

- Latency: 1 clock.
  - `in` is sampled at rising edge N.
  - code, valid and multi reflect that sample from edge N until edge N+1.
- Throughput: one new input per cycle. Back-to-back changes are each encoded independently.
- No combinational path from `in` to any output.
- Reset:
  - When rst=1 at a rising edge: code←0, valid←0, multi←0, regardless of `in`.
  - Reset takes priority over encoding in the same cycle.
- Mid-operation reset: the outputs show the reset value in the cycle after the asserting edge.
  - The first edge with rst=0 samples the current `in` normally. The encoding is visible one cycle later.
- Power-up before the first reset: outputs are undefined. Users must apply rst for ≥ 1 cycle.

## Test plan

- Reset: hold rst=1 with in=8'hFF for 2 cycles → code=0, valid=0, multi=0. Release rst → one cycle later code=7, valid=1, multi=1.
- Exhaustive sweep:
  - Stimulus: in from 0 to 255, incrementing by 1, each value held one clock.
  - Reference model: code = index of the MSB set, valid = (in≠0), multi = (popcount≥2).
  - Check each value one cycle after it is applied.
  - Spot checks: in=1 → 0/1/0. in=2 → 1/1/0. in=3 → 1/1/1. in=8'h80 → 7/1/0. in=8'hFF → 7/1/1.
- Zero vs bit-0 distinction: in=0 → code=0, valid=0. Next cycle in=1 → code=0, valid=1.
- Single-hot walk: in=1<<k for k=0..7 on consecutive cycles → code=k, valid=1, multi=0, each one cycle delayed.
- Reset mid-stream:
  - Apply in=8'h40, then assert rst for one cycle while in=8'h20.
  - Required response: 6/1/0, then 0/0/0, then 5/1/0 once rst is low.
- Latency and hold:
  - Change `in` between clock edges → outputs do not change until the next rising edge.
  - Hold in=8'h24 for 3 cycles → code=5, valid=1, multi=1, stable on all three cycles.
